conv_load_sequencer: RTL and testbench

Upstream feeder for the convolution compute stage. Issues cacheline read requests to the host read channel for a weight region and then an input-data region. Writes the returned 512-bit lines into the compute stage's weight and input-data cacheline buffers through the wr_addr / buffer_select / data write port. Pulses conv_start once enough input lines are resident, then holds until the compute stage reports completion.

---
 rtl/conv_load_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_conv_load_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_load_sequencer.sv
// Feeds the convolution compute stage: fetches a weight region, then an input-data region,
// writes returned lines into the cacheline buffers and launches the compute stage.
module conv_load_sequencer #(
    parameter int BUFFER_DEPTH    = 256,
    parameter int START_THRESHOLD = 12,
    parameter int MAX_OUTSTANDING = 8,
    parameter int ADDR_W          = 42
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              cfg_go,
    input  logic [ADDR_W-1:0] cfg_weight_base,
    input  logic [ADDR_W-1:0] cfg_data_base,
    input  logic [8:0]        cfg_num_weight_cl,
    input  logic [8:0]        cfg_num_data_cl,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              req_ready,
    input  logic              rsp_valid,
    input  logic [511:0]      rsp_data,
    output logic              wr_valid,
    output logic [7:0]        wr_addr,
    output logic [511:0]      wr_data,
    output logic              buffer_select,
    output logic              conv_start,
    input  logic              conv_done,
    output logic              busy,
    output logic              err_cfg
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT_CONV} state_t;

    // One extra bit over the 9-bit counts so a full 256+256 job can count up to 512.
    localparam int CNT_W = 10;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    state_t            state_q, state_d;
    logic [8:0]        num_w_q, num_w_d;
    logic [8:0]        num_d_q, num_d_d;
    logic [ADDR_W-1:0] wbase_q, wbase_d;
    logic [ADDR_W-1:0] dbase_q, dbase_d;
    logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]  rsp_cnt_q, rsp_cnt_d;
    logic [OUT_W-1:0]  outst_q, outst_d;
    logic              fired_q, fired_d;
    logic              wr_valid_q, wr_valid_d;
    logic [7:0]        wr_addr_q, wr_addr_d;
    logic [511:0]      wr_data_q, wr_data_d;
    logic              sel_q, sel_d;
    logic              conv_start_q, conv_start_d;
    logic              err_q, err_d;

    logic [CNT_W-1:0]  num_w_ext;
    logic [CNT_W-1:0]  total;
    logic [8:0]        thr_m1;
    logic              req_fire;
    logic              rsp_take;
    logic              cfg_bad;

    always_comb begin : derive
        num_w_ext = CNT_W'(num_w_q);
        total     = num_w_ext + CNT_W'(num_d_q);
        req_valid = (state_q == FETCH) && (req_cnt_q < total)
                    && (outst_q < OUT_W'(MAX_OUTSTANDING));
        req_addr  = '0;
        if (req_valid) begin
            if (req_cnt_q < num_w_ext) begin
                req_addr = wbase_q + ADDR_W'(req_cnt_q);
            end else begin
                req_addr = dbase_q + ADDR_W'(req_cnt_q - num_w_ext);
            end
        end
        req_fire = req_valid && req_ready;
        rsp_take = (state_q == FETCH) && rsp_valid;
        // Index of the data line whose write releases the compute stage.
        thr_m1   = (num_d_q < 9'(START_THRESHOLD)) ? (num_d_q - 9'd1)
                                                   : 9'(START_THRESHOLD - 1);
        cfg_bad  = (cfg_num_weight_cl == 9'd0) || (cfg_num_weight_cl > 9'(BUFFER_DEPTH))
                || (cfg_num_data_cl == 9'd0) || (cfg_num_data_cl > 9'(BUFFER_DEPTH));
    end

    always_comb begin : next_state
        state_d      = state_q;
        num_w_d      = num_w_q;
        num_d_d      = num_d_q;
        wbase_d      = wbase_q;
        dbase_d      = dbase_q;
        req_cnt_d    = req_cnt_q;
        rsp_cnt_d    = rsp_cnt_q;
        outst_d      = outst_q;
        fired_d      = fired_q;
        wr_valid_d   = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        sel_d        = sel_q;
        conv_start_d = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_go) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        num_w_d   = cfg_num_weight_cl;
                        num_d_d   = cfg_num_data_cl;
                        wbase_d   = cfg_weight_base;
                        dbase_d   = cfg_data_base;
                        req_cnt_d = '0;
                        rsp_cnt_d = '0;
                        outst_d   = '0;
                        fired_d   = 1'b0;
                        state_d   = FETCH;
                    end
                end
            end

            FETCH: begin
                if (req_fire) begin
                    req_cnt_d = req_cnt_q + CNT_W'(1);
                end
                if (req_fire && !rsp_take) begin
                    outst_d = outst_q + OUT_W'(1);
                end else if (!req_fire && rsp_take) begin
                    outst_d = outst_q - OUT_W'(1);
                end

                if (rsp_take) begin
                    wr_valid_d = 1'b1;
                    wr_data_d  = rsp_data;
                    rsp_cnt_d  = rsp_cnt_q + CNT_W'(1);
                    // Data-line addresses are below 256, so the low byte of the difference is exact.
                    if (rsp_cnt_q < num_w_ext) begin
                        sel_d     = 1'b1;
                        wr_addr_d = rsp_cnt_q[7:0];
                    end else begin
                        sel_d     = 1'b0;
                        wr_addr_d = rsp_cnt_q[7:0] - num_w_q[7:0];
                    end
                end

                if (wr_valid_q && !sel_q && !fired_q && ({1'b0, wr_addr_q} == thr_m1)) begin
                    conv_start_d = 1'b1;
                    fired_d      = 1'b1;
                end

                if ((rsp_cnt_q == total) && !wr_valid_q) begin
                    state_d = WAIT_CONV;
                end
            end

            WAIT_CONV: begin
                if (conv_done) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin : ctrl_regs
        if (!resetb) begin
            state_q      <= IDLE;
            req_cnt_q    <= '0;
            rsp_cnt_q    <= '0;
            outst_q      <= '0;
            fired_q      <= 1'b0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            sel_q        <= 1'b0;
            conv_start_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_cnt_q    <= req_cnt_d;
            rsp_cnt_q    <= rsp_cnt_d;
            outst_q      <= outst_d;
            fired_q      <= fired_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            sel_q        <= sel_d;
            conv_start_q <= conv_start_d;
            err_q        <= err_d;
        end
    end

    // Job configuration is only consumed in FETCH, which always follows a fresh latch.
    always_ff @(posedge clk) begin : cfg_regs
        num_w_q <= num_w_d;
        num_d_q <= num_d_d;
        wbase_q <= wbase_d;
        dbase_q <= dbase_d;
    end

    assign wr_valid      = wr_valid_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign buffer_select = sel_q;
    assign conv_start    = conv_start_q;
    assign err_cfg       = err_q;
    assign busy          = (state_q != IDLE);

    a_outst_bound: assert property (@(posedge clk) disable iff (!resetb)
        outst_q <= OUT_W'(MAX_OUTSTANDING));

    a_req_hold: assert property (@(posedge clk) disable iff (!resetb)
        (req_valid && !req_ready) |=> (req_valid && $stable(req_addr)));

    a_start_pulse: assert property (@(posedge clk) disable iff (!resetb)
        conv_start |=> !conv_start);

endmodule

// File: tb/tb_conv_load_sequencer.sv
// Randomized bench for conv_load_sequencer: a host model answers requests in order and a
// line-level reference predicts every request address, buffer write and start pulse.
module tb_conv_load_sequencer;

    localparam int ADDR_W = 42;
    localparam int TH     = 12;
    localparam int MAXO   = 8;

    typedef logic [511:0] vec_t;

    logic              clk = 1'b0;
    logic              resetb;
    logic              cfg_go;
    logic [ADDR_W-1:0] cfg_weight_base;
    logic [ADDR_W-1:0] cfg_data_base;
    logic [8:0]        cfg_num_weight_cl;
    logic [8:0]        cfg_num_data_cl;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic [511:0]      rsp_data;
    logic              wr_valid;
    logic [7:0]        wr_addr;
    logic [511:0]      wr_data;
    logic              buffer_select;
    logic              conv_start;
    logic              conv_done;
    logic              busy;
    logic              err_cfg;

    int n_vec = 0;
    int n_err = 0;

    conv_load_sequencer dut (
        .clk               (clk),
        .resetb            (resetb),
        .cfg_go            (cfg_go),
        .cfg_weight_base   (cfg_weight_base),
        .cfg_data_base     (cfg_data_base),
        .cfg_num_weight_cl (cfg_num_weight_cl),
        .cfg_num_data_cl   (cfg_num_data_cl),
        .req_valid         (req_valid),
        .req_addr          (req_addr),
        .req_ready         (req_ready),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .wr_valid          (wr_valid),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .buffer_select     (buffer_select),
        .conv_start        (conv_start),
        .conv_done         (conv_done),
        .busy              (busy),
        .err_cfg           (err_cfg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input vec_t got, input vec_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rand_line(output logic [511:0] d);
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
    endtask

    // One job: rdy_mode 0 = always ready, 1 = alternate, 2 = random.
    // Responses return dly in [min_dly,max_dly] cycles after acceptance, in order.
    task automatic run_job(input int nw, input int nd, input int rdy_mode, input int min_dly,
                           input int max_dly, input bit gaps, input int hold_cyc,
                           input bit noise, input int abort_at);
        logic [ADDR_W-1:0] wb, db;
        logic [ADDR_W-1:0] ea[$];
        int                due[$];
        int                t, thr, issued, sent, wr_seen, starts, cyc, done_at, done_cyc, extra;
        bit                nxt_v, nxt_sel, start_exp, prev_sel, exp_rv;
        logic [7:0]        nxt_addr;
        logic [511:0]      nxt_data;

        wb  = ADDR_W'({$urandom(), $urandom()});
        db  = ADDR_W'({$urandom(), $urandom()});
        t   = nw + nd;
        thr = (nd < TH) ? nd : TH;
        for (int k = 0; k < nw; k++) ea.push_back(wb + ADDR_W'(k));
        for (int k = 0; k < nd; k++) ea.push_back(db + ADDR_W'(k));
        issued = 0; sent = 0; wr_seen = 0; starts = 0;
        done_at = -1; done_cyc = -1; extra = $urandom_range(0, 3);
        nxt_v = 1'b0; nxt_sel = 1'b0; start_exp = 1'b0; prev_sel = 1'b0;
        nxt_addr = '0; nxt_data = '0;

        chk("idle_busy", vec_t'(busy), vec_t'(0));
        chk("idle_req_valid", vec_t'(req_valid), vec_t'(0));
        cfg_weight_base   = wb;
        cfg_data_base     = db;
        cfg_num_weight_cl = 9'(nw);
        cfg_num_data_cl   = 9'(nd);
        cfg_go            = 1'b1;
        @(negedge clk);
        cfg_go = 1'b0;

        cyc = 0;
        while (1) begin
            if (done_cyc >= 0) begin
                chk("busy_after_done", vec_t'(busy), vec_t'(0));
                chk("start_count", vec_t'(starts), vec_t'(1));
                break;
            end
            if (cyc > 6000) begin
                chk("timeout_writes", vec_t'(wr_seen), vec_t'(t));
                break;
            end

            chk("busy", vec_t'(busy), vec_t'(1));
            exp_rv = (issued < t) && (due.size() < MAXO);
            chk("req_valid", vec_t'(req_valid), vec_t'(exp_rv));
            if (exp_rv) chk("req_addr", vec_t'(req_addr), vec_t'(ea[issued]));
            chk("wr_valid", vec_t'(wr_valid), vec_t'(nxt_v));
            if (nxt_v) begin
                chk("wr_data", wr_data, nxt_data);
                chk("wr_addr", vec_t'(wr_addr), vec_t'(nxt_addr));
                chk("buffer_select", vec_t'(buffer_select), vec_t'(nxt_sel));
            end else if (wr_seen > 0) begin
                chk("sel_hold", vec_t'(buffer_select), vec_t'(prev_sel));
            end
            chk("conv_start", vec_t'(conv_start), vec_t'(start_exp));
            chk("err_cfg_quiet", vec_t'(err_cfg), vec_t'(0));
            if (conv_start) starts++;

            start_exp = nxt_v && !nxt_sel && (int'(nxt_addr) == thr - 1);
            if (nxt_v) begin
                prev_sel = nxt_sel;
                wr_seen++;
                if (wr_seen == t) done_at = cyc;
            end

            if (abort_at > 0 && cyc == abort_at) begin
                resetb    = 1'b0;
                rsp_valid = 1'b0;
                req_ready = 1'b0;
                break;
            end

            case (rdy_mode)
                0:       req_ready = 1'b1;
                1:       req_ready = (cyc % 2 == 0);
                default: req_ready = 1'($urandom_range(0, 1));
            endcase
            if (exp_rv && req_ready) begin
                due.push_back(cyc + int'($urandom_range(min_dly, max_dly)));
                issued++;
            end

            if (due.size() > 0 && due[0] <= cyc && cyc >= hold_cyc
                && !(gaps && $urandom_range(0, 2) == 0)) begin
                void'(due.pop_front());
                rsp_valid = 1'b1;
                rand_line(rsp_data);
                nxt_v    = 1'b1;
                nxt_data = rsp_data;
                nxt_sel  = (sent < nw);
                nxt_addr = 8'(nxt_sel ? sent : sent - nw);
                sent++;
            end else begin
                rsp_valid = 1'b0;
                nxt_v     = 1'b0;
            end

            cfg_go = noise && (cyc == 4);
            if (cfg_go) begin
                cfg_num_weight_cl = 9'd0;
                cfg_num_data_cl   = 9'd3;
            end
            conv_done = (noise && cyc == 6);
            if (done_at >= 0 && cyc == done_at + 2 + extra) begin
                conv_done = 1'b1;
                done_cyc  = cyc;
            end

            @(negedge clk);
            cyc++;
        end
        cfg_go    = 1'b0;
        conv_done = 1'b0;
        rsp_valid = 1'b0;

        if (abort_at > 0) begin
            @(negedge clk);
            chk("rst_busy", vec_t'(busy), vec_t'(0));
            chk("rst_req_valid", vec_t'(req_valid), vec_t'(0));
            chk("rst_wr_valid", vec_t'(wr_valid), vec_t'(0));
            resetb = 1'b1;
            while (due.size() > 0) begin
                void'(due.pop_front());
                rsp_valid = 1'b1;
                rand_line(rsp_data);
                @(negedge clk);
                chk("stale_wr_valid", vec_t'(wr_valid), vec_t'(0));
                chk("stale_conv_start", vec_t'(conv_start), vec_t'(0));
                chk("stale_busy", vec_t'(busy), vec_t'(0));
            end
            rsp_valid = 1'b0;
            @(negedge clk);
            chk("stale_wr_final", vec_t'(wr_valid), vec_t'(0));
        end
    endtask

    task automatic cfg_err(input int nw, input int nd);
        cfg_num_weight_cl = 9'(nw);
        cfg_num_data_cl   = 9'(nd);
        cfg_go            = 1'b1;
        @(negedge clk);
        cfg_go = 1'b0;
        chk("err_pulse", vec_t'(err_cfg), vec_t'(1));
        chk("err_busy", vec_t'(busy), vec_t'(0));
        @(negedge clk);
        chk("err_single", vec_t'(err_cfg), vec_t'(0));
        chk("err_busy_after", vec_t'(busy), vec_t'(0));
        chk("err_req_valid", vec_t'(req_valid), vec_t'(0));
    endtask

    initial begin
        int nw, nd;
        resetb            = 1'b0;
        cfg_go            = 1'b0;
        cfg_weight_base   = '0;
        cfg_data_base     = '0;
        cfg_num_weight_cl = '0;
        cfg_num_data_cl   = '0;
        req_ready         = 1'b0;
        rsp_valid         = 1'b0;
        rsp_data          = '0;
        conv_done         = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_req_valid0", vec_t'(req_valid), vec_t'(0));
        chk("rst_req_addr0", vec_t'(req_addr), vec_t'(0));
        chk("rst_wr_valid0", vec_t'(wr_valid), vec_t'(0));
        chk("rst_wr_addr0", vec_t'(wr_addr), vec_t'(0));
        chk("rst_wr_data0", wr_data, vec_t'(0));
        chk("rst_sel0", vec_t'(buffer_select), vec_t'(0));
        chk("rst_conv_start0", vec_t'(conv_start), vec_t'(0));
        chk("rst_busy0", vec_t'(busy), vec_t'(0));
        chk("rst_err0", vec_t'(err_cfg), vec_t'(0));
        resetb = 1'b1;
        @(negedge clk);

        run_job(4, 16, 0, 3, 3, 1'b0, 0, 1'b0, 0);
        run_job(2, 5, 0, 3, 3, 1'b0, 0, 1'b0, 0);
        run_job(6, 20, 0, 1, 2, 1'b0, 30, 1'b0, 0);
        run_job(256, 256, 1, 1, 5, 1'b1, 0, 1'b1, 0);
        cfg_err(4, 0);
        cfg_err(257, 4);
        cfg_err(0, 3);
        run_job(10, 30, 2, 1, 4, 1'b1, 0, 1'b0, 15);
        run_job(3, 12, 0, 1, 3, 1'b0, 0, 1'b0, 0);
        for (int j = 0; j < 6; j++) begin
            nw = int'($urandom_range(1, 40));
            nd = int'($urandom_range(1, 40));
            run_job(nw, nd, int'($urandom_range(0, 2)), 1, int'($urandom_range(1, 6)),
                    1'($urandom_range(0, 1)), (j % 2 == 0) ? 12 : 0, (nw + nd) >= 20, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
